// File: rtl/cali_hsv_multi_if.sv
// Bus bundle for cali_hsv_multi: pixel stream, calibration
// control and the slot read port.
interface cali_hsv_multi_if #(
    parameter int PIX_W   = 8,
    parameter int COORD_W = 13,
    parameter int SLOTS   = 4
);
    localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    logic                    pix_valid;
    logic                    sof;
    logic [PIX_W-1:0]        raw_R;
    logic [PIX_W-1:0]        raw_G;
    logic [PIX_W-1:0]        raw_B;
    logic [COORD_W-1:0]      row;
    logic [COORD_W-1:0]      col;
    logic [COORD_W-1:0]      c_row;
    logic [COORD_W-1:0]      c_col;
    logic                    start;
    logic [SLOT_W-1:0]       slot_sel;
    logic                    busy;
    logic                    done;
    logic [SLOT_W-1:0]       rd_slot;
    logic                    rd_rgb;
    logic signed [PIX_W+2:0] H_out;
    logic [PIX_W-1:0]        S_out;
    logic [PIX_W-1:0]        V_out;

    modport master (
        output pix_valid, sof, raw_R, raw_G, raw_B,
        output row, col, c_row, c_col,
        output start, slot_sel, rd_slot, rd_rgb,
        input  busy, done, H_out, S_out, V_out
    );

    modport slave (
        input  pix_valid, sof, raw_R, raw_G, raw_B,
        input  row, col, c_row, c_col,
        input  start, slot_sel, rd_slot, rd_rgb,
        output busy, done, H_out, S_out, V_out
    );
endinterface

// File: rtl/cali_hsv_multi.sv
// Windowed colour averager producing per-slot H/S/V calibration values.
// Define CALI_RGB_OUT_EN to also keep the averaged R/G/B in every slot.
module cali_hsv_multi #(
    parameter int PIX_W    = 8,
    parameter int COORD_W  = 13,
    parameter int WIN_LOG2 = 3,
    parameter int SLOTS    = 4
) (
    input logic             clk,
    input logic             reset,
    cali_hsv_multi_if.slave cal
);
    localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int ACC_W  = PIX_W + 2 * WIN_LOG2;
    localparam int CNT_W  = 2 * WIN_LOG2 + 1;
    localparam int H_W    = PIX_W + 3;
    localparam logic [CNT_W-1:0] N_SAMP =
        CNT_W'(1 << (2 * WIN_LOG2));
    localparam logic [COORD_W:0] WIN_M1 =
        (COORD_W + 1)'((1 << WIN_LOG2) - 1);

    typedef enum logic [2:0] {
        IDLE, ACCUM, AVG, MAXMIN, HSV, DONE
    } state_t;

    state_t            state;
    logic [SLOT_W-1:0] slot_q;
    logic [ACC_W-1:0]  acc_r, acc_g, acc_b;
    logic [CNT_W-1:0]  cnt;
    logic [PIX_W-1:0]  avg_r, avg_g, avg_b;
    logic [PIX_W-1:0]  mx, mn;
    logic              busy, done;

    logic [H_W-1:0]    h_mem [SLOTS];
    logic [PIX_W-1:0]  s_mem [SLOTS];
    logic [PIX_W-1:0]  v_mem [SLOTS];
`ifdef CALI_RGB_OUT_EN
    logic [PIX_W-1:0]  r_mem [SLOTS];
    logic [PIX_W-1:0]  g_mem [SLOTS];
    logic [PIX_W-1:0]  b_mem [SLOTS];
`endif

    // Extra top bit keeps c+WIN-1 from wrapping back into range.
    logic [COORD_W:0] row_x, col_x, crow_x, ccol_x;
    logic             in_win;

    assign row_x  = {1'b0, cal.row};
    assign col_x  = {1'b0, cal.col};
    assign crow_x = {1'b0, cal.c_row};
    assign ccol_x = {1'b0, cal.c_col};

    assign in_win = cal.pix_valid
                 && row_x >= crow_x
                 && row_x <= crow_x + WIN_M1
                 && col_x >= ccol_x
                 && col_x <= ccol_x + WIN_M1;

    logic [ACC_W-1:0] nxt_r, nxt_g, nxt_b;
    logic [CNT_W-1:0] nxt_cnt;

    always_comb begin
        nxt_r   = cal.sof ? '0 : acc_r;
        nxt_g   = cal.sof ? '0 : acc_g;
        nxt_b   = cal.sof ? '0 : acc_b;
        nxt_cnt = cal.sof ? '0 : cnt;
        if (in_win) begin
            nxt_r   = nxt_r + ACC_W'(cal.raw_R);
            nxt_g   = nxt_g + ACC_W'(cal.raw_G);
            nxt_b   = nxt_b + ACC_W'(cal.raw_B);
            nxt_cnt = nxt_cnt + CNT_W'(1);
        end
    end

    logic [PIX_W-1:0] mx_c, mn_c;

    always_comb begin
        mx_c = avg_r;
        mn_c = avg_r;
        if (avg_g > mx_c) mx_c = avg_g;
        if (avg_b > mx_c) mx_c = avg_b;
        if (avg_g < mn_c) mn_c = avg_g;
        if (avg_b < mn_c) mn_c = avg_b;
    end

    logic [PIX_W-1:0] diff;
    logic [H_W-1:0]   er, eg, eb, ed, h_val;

    assign diff = mx - mn;
    assign er   = H_W'(avg_r);
    assign eg   = H_W'(avg_g);
    assign eb   = H_W'(avg_b);
    assign ed   = H_W'(diff);

    // Two's-complement wrap in H_W bits gives the signed hue.
    always_comb begin
        if (avg_r == mx)
            h_val = eg - eb;
        else if (avg_g == mx)
            h_val = eb - er + (ed << 1);
        else
            h_val = er - eg + (ed << 2);
    end

    logic wr_ok;
    assign wr_ok = int'(slot_q) < SLOTS;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            slot_q <= '0;
            acc_r  <= '0;
            acc_g  <= '0;
            acc_b  <= '0;
            cnt    <= '0;
            avg_r  <= '0;
            avg_g  <= '0;
            avg_b  <= '0;
            mx     <= '0;
            mn     <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            for (int i = 0; i < SLOTS; i++) begin
                h_mem[i] <= '0;
                s_mem[i] <= '0;
                v_mem[i] <= '0;
`ifdef CALI_RGB_OUT_EN
                r_mem[i] <= '0;
                g_mem[i] <= '0;
                b_mem[i] <= '0;
`endif
            end
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cal.start) begin
                        slot_q <= cal.slot_sel;
                        acc_r  <= '0;
                        acc_g  <= '0;
                        acc_b  <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (!cal.start) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        acc_r <= nxt_r;
                        acc_g <= nxt_g;
                        acc_b <= nxt_b;
                        cnt   <= nxt_cnt;
                        if (nxt_cnt == N_SAMP) state <= AVG;
                    end
                end
                AVG: begin
                    if (!cal.start) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        avg_r <= acc_r[ACC_W-1 -: PIX_W];
                        avg_g <= acc_g[ACC_W-1 -: PIX_W];
                        avg_b <= acc_b[ACC_W-1 -: PIX_W];
                        state <= MAXMIN;
                    end
                end
                MAXMIN: begin
                    if (!cal.start) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        mx    <= mx_c;
                        mn    <= mn_c;
                        state <= HSV;
                    end
                end
                HSV: begin
                    if (!cal.start) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        if (wr_ok) begin
                            h_mem[slot_q] <= h_val;
                            s_mem[slot_q] <= diff;
                            v_mem[slot_q] <= mx;
`ifdef CALI_RGB_OUT_EN
                            r_mem[slot_q] <= avg_r;
                            g_mem[slot_q] <= avg_g;
                            b_mem[slot_q] <= avg_b;
`endif
                        end
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (!cal.start) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign cal.busy = busy;
    assign cal.done = done;

    logic rd_ok;
    assign rd_ok = int'(cal.rd_slot) < SLOTS;

`ifndef CALI_RGB_OUT_EN
    logic unused_rd_rgb;
    assign unused_rd_rgb = cal.rd_rgb;
`endif

    always_comb begin
        cal.H_out = '0;
        cal.S_out = '0;
        cal.V_out = '0;
        if (rd_ok) begin
            cal.H_out = h_mem[cal.rd_slot];
            cal.S_out = s_mem[cal.rd_slot];
            cal.V_out = v_mem[cal.rd_slot];
`ifdef CALI_RGB_OUT_EN
            if (cal.rd_rgb) begin
                cal.H_out = H_W'(r_mem[cal.rd_slot]);
                cal.S_out = g_mem[cal.rd_slot];
                cal.V_out = b_mem[cal.rd_slot];
            end
`endif
        end
    end
endmodule
